seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 18 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter sizing helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Counter must hold 0..w-1.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/Busy/Done handshake and operand/result bus between the pipeline
// control (master) and the divider (slave).
interface seq_divider_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivZero;

  modport master (
    output Start, Signed, X, Y,
    input  Busy, Done, Quotient, Remainder, DivZero
  );

  modport slave (
    input  Start, Signed, X, Y,
    output Busy, Done, Quotient, Remainder, DivZero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract the
// divisor from the widened partial remainder and keep it if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    // A failed trial means shifted < divisor, so it still fits in WIDTH bits.
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (div/divu) with Start/Busy/Done
// handshake; signed operands are divided as magnitudes and fixed up at the end.
module seq_divider import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          CLK,
  input  logic          RST,
  seq_divider_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             divzero_q, divzero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (bus.Start) begin
          cnt_d  = '0;
          rem_d  = '0;
          qneg_d = bus.Signed & (bus.X[WIDTH-1] ^ bus.Y[WIDTH-1]);
          rneg_d = bus.Signed & bus.X[WIDTH-1];
          dvs_d  = (bus.Signed && bus.Y[WIDTH-1]) ? -bus.Y : bus.Y;
          if (bus.Y == '0) begin
            // Keep the raw dividend; it is returned unmodified as the remainder.
            dz_d    = 1'b1;
            quo_d   = bus.X;
            state_d = DIV_FIX;
          end else begin
            dz_d    = 1'b0;
            quo_d   = (bus.Signed && bus.X[WIDTH-1]) ? -bus.X : bus.X;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        done_d  = 1'b1;
        state_d = DIV_IDLE;
        if (dz_q) begin
          quot_d    = '1;
          remo_d    = quo_q;
          divzero_d = 1'b1;
        end else begin
          quot_d    = qneg_q ? -quo_q : quo_q;
          remo_d    = rneg_q ? -rem_q : rem_q;
          divzero_d = 1'b0;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign bus.Busy      = (state_q != DIV_IDLE);
  assign bus.Done      = done_q;
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = remo_q;
  assign bus.DivZero   = divzero_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, sign combinations,
// divide-by-zero, edge operands, handshake corner cases and mid-run reset.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Issue one operation and wait (bounded) for Done; lat = -1 on timeout.
  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy_cnt,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    @(negedge clk);
    bus.Start = 1'b1; bus.Signed = s; bus.X = x; bus.Y = y;
    @(negedge clk);
    bus.Start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!bus.Done) begin
      if (bus.Busy) busy_cnt++;
      if (lat >= 60) begin lat = -1; break; end
      @(negedge clk);
      lat++;
    end
    q = bus.Quotient; r = bus.Remainder; dz = bus.DivZero;
    $display("op s=%0d x=%h y=%h -> q=%h r=%h dz=%0d lat=%0d", s, x, y, q, r, dz, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.Start = 1'b0; bus.Signed = 1'b0; bus.X = '0; bus.Y = '0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.Done); end
    if (bus.Quotient !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp 0", bus.Quotient); end
    if (bus.Remainder !== 32'h0) begin errors++; $display("FAIL reset_r got %h exp 0", bus.Remainder); end
    if (bus.DivZero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", bus.DivZero); end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_unsigned_basic();
    int lat, bc; logic [31:0] q, r; logic dz;
    do_op(1'b0, 32'd100, 32'd7, lat, bc, q, r, dz);
    checks += 5;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d exp 33", lat); end
    if (bc !== 33) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 33", bc); end
    if (q !== 32'd14) begin errors++; $display("FAIL basic_q got %h exp %h", q, 32'd14); end
    if (r !== 32'd2) begin errors++; $display("FAIL basic_r got %h exp %h", r, 32'd2); end
    if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz got %b exp 0", dz); end
    @(negedge clk);
    checks += 2;
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", bus.Done); end
    if (bus.Quotient !== 32'd14) begin errors++; $display("FAIL q_hold got %h exp %h", bus.Quotient, 32'd14); end
  endtask

  task automatic test_signed();
    logic [31:0] xs [3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] ys [3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] eq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    logic [31:0] er [3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    int lat, bc; logic [31:0] q, r; logic dz;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, xs[i], ys[i], lat, bc, q, r, dz);
      checks += 3;
      if (q !== eq[i]) begin errors++; $display("FAIL signed_q[%0d] got %h exp %h", i, q, eq[i]); end
      if (r !== er[i]) begin errors++; $display("FAIL signed_r[%0d] got %h exp %h", i, r, er[i]); end
      if (lat !== 33) begin errors++; $display("FAIL signed_lat[%0d] got %0d exp 33", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [31:0] q, r; logic dz;
    do_op(1'b1, 32'h1234_5678, 32'h0, lat, bc, q, r, dz);
    checks += 4;
    if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
    if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q got %h exp ffffffff", q); end
    if (r !== 32'h1234_5678) begin errors++; $display("FAIL dz_r got %h exp 12345678", r); end
    if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", dz); end
    do_op(1'b0, 32'd9, 32'd3, lat, bc, q, r, dz);
    checks += 3;
    if (q !== 32'd3) begin errors++; $display("FAIL after_dz_q got %h exp 3", q); end
    if (r !== 32'd0) begin errors++; $display("FAIL after_dz_r got %h exp 0", r); end
    if (dz !== 1'b0) begin errors++; $display("FAIL after_dz_flag got %b exp 0", dz); end
  endtask

  task automatic test_edges();
    logic        ss [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] xs [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] ys [3] = '{32'hFFFF_FFFF, 32'd1, 32'd9};
    logic [31:0] eq [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] er [3] = '{32'd0, 32'd0, 32'd5};
    int lat, bc; logic [31:0] q, r; logic dz;
    for (int i = 0; i < 3; i++) begin
      do_op(ss[i], xs[i], ys[i], lat, bc, q, r, dz);
      checks += 3;
      if (q !== eq[i]) begin errors++; $display("FAIL edge_q[%0d] got %h exp %h", i, q, eq[i]); end
      if (r !== er[i]) begin errors++; $display("FAIL edge_r[%0d] got %h exp %h", i, r, er[i]); end
      if (dz !== 1'b0) begin errors++; $display("FAIL edge_dz[%0d] got %b exp 0", i, dz); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    @(negedge clk);
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.X = 32'd100; bus.Y = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    lat = 0;
    while (!bus.Done && lat < 60) begin
      bus.Start = (lat == 5 || lat == 20);
      bus.X = 32'd50 + 32'(lat); bus.Y = 32'd5; bus.Signed = 1'b1;
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
    $display("busy_start q=%h r=%h lat=%0d", bus.Quotient, bus.Remainder, lat);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL busy_start_lat got %0d exp 33", lat); end
    if (bus.Quotient !== 32'd14) begin errors++; $display("FAIL busy_start_q got %h exp %h", bus.Quotient, 32'd14); end
    if (bus.Remainder !== 32'd2) begin errors++; $display("FAIL busy_start_r got %h exp 2", bus.Remainder); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [31:0] q, r; logic dz;
    do_op(1'b0, 32'd100, 32'd7, lat, bc, q, r, dz);
    // Still in the Done cycle: request the next op right away.
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.X = 32'd50; bus.Y = 32'd5;
    @(negedge clk);
    bus.Start = 1'b0;
    checks += 3;
    if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", bus.Busy); end
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b exp 0", bus.Done); end
    if (bus.Quotient !== 32'd14) begin errors++; $display("FAIL b2b_hold_q got %h exp %h", bus.Quotient, 32'd14); end
    lat = 0;
    while (!bus.Done && lat < 60) begin @(negedge clk); lat++; end
    $display("b2b q=%h r=%h lat=%0d", bus.Quotient, bus.Remainder, lat);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL b2b_lat got %0d exp 33", lat); end
    if (bus.Quotient !== 32'd10) begin errors++; $display("FAIL b2b_q got %h exp %h", bus.Quotient, 32'd10); end
    if (bus.Remainder !== 32'd0) begin errors++; $display("FAIL b2b_r got %h exp 0", bus.Remainder); end
  endtask

  task automatic test_reset_midrun();
    int lat, bc, done_seen; logic [31:0] q, r; logic dz;
    @(negedge clk);
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.X = 32'd100; bus.Y = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.Busy); end
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", bus.Done); end
    if (bus.Quotient !== 32'd0) begin errors++; $display("FAIL midrst_q got %h exp 0", bus.Quotient); end
    if (bus.Remainder !== 32'd0) begin errors++; $display("FAIL midrst_r got %h exp 0", bus.Remainder); end
    done_seen = 0;
    repeat (40) begin @(negedge clk); if (bus.Done) done_seen++; end
    $display("midrst done pulses after abort=%0d", done_seen);
    checks += 1;
    if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_seen); end
    do_op(1'b0, 32'd100, 32'd7, lat, bc, q, r, dz);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL midrst_restart_lat got %0d exp 33", lat); end
    if (q !== 32'd14) begin errors++; $display("FAIL midrst_restart_q got %h exp %h", q, 32'd14); end
    if (r !== 32'd2) begin errors++; $display("FAIL midrst_restart_r got %h exp 2", r); end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_edges();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
